// File: rtl/pipeline_pkg.sv
// Shared pipeline memory-port defaults and the arbiter state encoding.
// Pure declarations: no latency or backpressure of its own.
package pipeline_pkg;

   localparam int ADDR_W_DEF  = 32;
   localparam int DATA_W_DEF  = 32;
   localparam int TIMEOUT_DEF = 15;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      BUSY_IF  = 2'd1,
      BUSY_MEM = 2'd2
   } arb_state_t;

   // Data access outranks instruction fetch so a stalled load/store never starves the pipeline.
   function automatic arb_state_t pick_grant(input logic mem_ok, input logic if_ok);
      arb_state_t nxt;
      nxt = IDLE;
      if (mem_ok) begin
         nxt = BUSY_MEM;
      end else if (if_ok) begin
         nxt = BUSY_IF;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/arb_timeout_counter.sv
// Counts memory wait cycles for the granted access; expired fires combinationally on the last allowed cycle.
// Zero latency on expired; ready in the same cycle always suppresses expiry.
module arb_timeout_counter
   import pipeline_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF
)(
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   input  logic ready,
   output logic expired
);

   localparam int               CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count <= '0;
      end else if (enable && !ready) begin
         count <= count + CNT_W'(1);
      end
   end

   // This cycle would be the TIMEOUT-th wait without a response.
   assign expired = enable && !ready && (count == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory port between IF and MEM (MEM first); request-to-valid is 2 cycles plus memory wait.
// Requesters hold req and see stall until their one-cycle valid; a silent memory is abandoned after TIMEOUT cycles.
module mem_port_arbiter
   import pipeline_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_valid,
   input  logic              mem_req,
   input  logic              mem_we,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_wdata,
   output logic [DATA_W-1:0] mem_rdata,
   output logic              mem_valid,
   output logic              port_req,
   output logic              port_we,
   output logic [ADDR_W-1:0] port_addr,
   output logic [DATA_W-1:0] port_wdata,
   input  logic [DATA_W-1:0] port_rdata,
   input  logic              port_ready,
   output logic              stall_IF,
   output logic              stall_MEM,
   output logic              timeout_err
);

   arb_state_t state;
   arb_state_t state_nxt;
   logic       grant_if;
   logic       grant_mem;
   logic       done_ok;
   logic       done_to;
   logic       busy;
   logic       owner_mem;
   logic       expired;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // A requester whose valid is pulsing this cycle is not eligible, so a held request is not serviced twice.
   always_comb begin
      state_nxt = state;
      grant_if  = 1'b0;
      grant_mem = 1'b0;
      done_ok   = 1'b0;
      done_to   = 1'b0;
      case (state)
         IDLE: begin
            state_nxt = pick_grant(mem_req && !mem_valid, if_req && !if_valid);
            grant_mem = (state_nxt == BUSY_MEM);
            grant_if  = (state_nxt == BUSY_IF);
         end
         BUSY_IF, BUSY_MEM: begin
            if (port_ready) begin
               done_ok   = 1'b1;
               state_nxt = IDLE;
            end else if (expired) begin
               done_to   = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign busy      = (state == BUSY_IF) || (state == BUSY_MEM);
   assign owner_mem = (state == BUSY_MEM);

   arb_timeout_counter #(
      .TIMEOUT (TIMEOUT)
   ) u_wait (
      .clk     (clk),
      .reset   (reset),
      .clear   (grant_if || grant_mem),
      .enable  (busy),
      .ready   (port_ready),
      .expired (expired)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         port_req    <= 1'b0;
         port_we     <= 1'b0;
         port_addr   <= '0;
         port_wdata  <= '0;
         if_rdata    <= '0;
         mem_rdata   <= '0;
         if_valid    <= 1'b0;
         mem_valid   <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         if_valid  <= 1'b0;
         mem_valid <= 1'b0;

         if (grant_mem) begin
            port_req   <= 1'b1;
            port_we    <= mem_we;
            port_addr  <= mem_addr;
            port_wdata <= mem_wdata;
         end else if (grant_if) begin
            port_req   <= 1'b1;
            port_we    <= 1'b0;
            port_addr  <= if_addr;
            port_wdata <= '0;
         end else if (done_ok || done_to) begin
            port_req   <= 1'b0;
         end

         if (done_ok) begin
            if (owner_mem) begin
               mem_valid <= 1'b1;
               if (!port_we) begin
                  mem_rdata <= port_rdata;
               end
            end else begin
               if_valid <= 1'b1;
               if_rdata <= port_rdata;
            end
         end

         // Abandoned access still completes toward the requester, with zero data, so the pipeline can move on.
         if (done_to) begin
            timeout_err <= 1'b1;
            if (owner_mem) begin
               mem_valid <= 1'b1;
               mem_rdata <= '0;
            end else begin
               if_valid <= 1'b1;
               if_rdata <= '0;
            end
         end
      end
   end

   assign stall_MEM = mem_req && !mem_valid;
   assign stall_IF  = (if_req && !if_valid) || stall_MEM;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic checked against a per-transaction timeline model.
module tb_mem_port_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 15;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          if_req = 1'b0;
   logic [AW-1:0] if_addr = '0;
   logic          mem_req = 1'b0;
   logic          mem_we = 1'b0;
   logic [AW-1:0] mem_addr = '0;
   logic [DW-1:0] mem_wdata = '0;
   logic [DW-1:0] port_rdata = '0;
   logic          port_ready = 1'b0;
   logic [DW-1:0] if_rdata;
   logic          if_valid;
   logic [DW-1:0] mem_rdata;
   logic          mem_valid;
   logic          port_req;
   logic          port_we;
   logic [AW-1:0] port_addr;
   logic [DW-1:0] port_wdata;
   logic          stall_IF;
   logic          stall_MEM;
   logic          timeout_err;

   int            n_cmp = 0;
   int            n_bad = 0;
   logic          exp_err = 1'b0;
   logic [DW-1:0] exp_if_rd = '0;
   logic [DW-1:0] exp_mem_rd = '0;

   mem_port_arbiter #(
      .ADDR_W  (AW),
      .DATA_W  (DW),
      .TIMEOUT (TO)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .if_req      (if_req),
      .if_addr     (if_addr),
      .if_rdata    (if_rdata),
      .if_valid    (if_valid),
      .mem_req     (mem_req),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata),
      .mem_valid   (mem_valid),
      .port_req    (port_req),
      .port_we     (port_we),
      .port_addr   (port_addr),
      .port_wdata  (port_wdata),
      .port_rdata  (port_rdata),
      .port_ready  (port_ready),
      .stall_IF    (stall_IF),
      .stall_MEM   (stall_MEM),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      reset      = 1'b1;
      if_req     = 1'b0;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      port_ready = 1'b0;
      port_rdata = '0;
      step();
      step();
      reset      = 1'b0;
      exp_err    = 1'b0;
      exp_if_rd  = '0;
      exp_mem_rd = '0;
   endtask

   // Timeline model: a grant at edge g completes at edge g+L+1 when the memory answers after L idle
   // wait cycles (L < TO), otherwise at edge g+TO with zero data. MEM is granted first at edge 1; a
   // waiting IF is granted on the edge right after MEM's valid cycle.
   task automatic run_arbitration(input string tag, input bit use_if, input bit use_mem, input bit we,
                                  input logic [AW-1:0] ia, input logic [AW-1:0] ma, input logic [DW-1:0] wd,
                                  input int lat_if, input int lat_mem,
                                  input logic [DW-1:0] rd_if, input logic [DW-1:0] rd_mem, input bit stray);
      int g_if, d_if, g_mem, d_mem, last;
      bit busy_if, busy_mem, v_if, v_mem, exp_req, exp_sm, exp_si;
      g_if = 0; d_if = 0; g_mem = 0; d_mem = 0;
      if (use_mem) begin
         g_mem = 1;
         d_mem = g_mem + ((lat_mem < TO) ? lat_mem + 1 : TO);
      end
      if (use_if) begin
         g_if = use_mem ? d_mem + 1 : 1;
         d_if = g_if + ((lat_if < TO) ? lat_if + 1 : TO);
      end
      last = (d_if > d_mem) ? d_if : d_mem;

      if_req = use_if; if_addr = ia;
      mem_req = use_mem; mem_we = we; mem_addr = ma; mem_wdata = wd;
      port_ready = 1'b0;
      #1;
      n_cmp++; if (stall_MEM !== use_mem) begin n_bad++; $display("FAIL %s stall_MEM k=0: got %b want %b", tag, stall_MEM, use_mem); end
      n_cmp++; if (stall_IF !== (use_if | use_mem)) begin n_bad++; $display("FAIL %s stall_IF k=0: got %b want %b", tag, stall_IF, use_if | use_mem); end

      for (int k = 1; k <= last + 1; k++) begin
         step();
         busy_mem = use_mem && (k >= g_mem) && (k < d_mem);
         busy_if  = use_if && (k >= g_if) && (k < d_if);
         v_mem    = use_mem && (k == d_mem);
         v_if     = use_if && (k == d_if);
         exp_req  = busy_mem || busy_if;
         if (v_if) begin
            if (lat_if < TO) exp_if_rd = rd_if;
            else begin exp_if_rd = '0; exp_err = 1'b1; end
         end
         if (v_mem) begin
            if (lat_mem >= TO) begin exp_mem_rd = '0; exp_err = 1'b1; end
            else if (!we) exp_mem_rd = rd_mem;
         end

         n_cmp++; if (port_req !== exp_req) begin n_bad++; $display("FAIL %s port_req k=%0d: got %b want %b", tag, k, port_req, exp_req); end
         n_cmp++; if (if_valid !== v_if) begin n_bad++; $display("FAIL %s if_valid k=%0d: got %b want %b", tag, k, if_valid, v_if); end
         n_cmp++; if (mem_valid !== v_mem) begin n_bad++; $display("FAIL %s mem_valid k=%0d: got %b want %b", tag, k, mem_valid, v_mem); end
         n_cmp++; if (if_rdata !== exp_if_rd) begin n_bad++; $display("FAIL %s if_rdata k=%0d: got %h want %h", tag, k, if_rdata, exp_if_rd); end
         n_cmp++; if (mem_rdata !== exp_mem_rd) begin n_bad++; $display("FAIL %s mem_rdata k=%0d: got %h want %h", tag, k, mem_rdata, exp_mem_rd); end
         n_cmp++; if (timeout_err !== exp_err) begin n_bad++; $display("FAIL %s timeout_err k=%0d: got %b want %b", tag, k, timeout_err, exp_err); end
         if (busy_mem) begin
            n_cmp++; if (port_addr !== ma) begin n_bad++; $display("FAIL %s port_addr(mem) k=%0d: got %h want %h", tag, k, port_addr, ma); end
            n_cmp++; if (port_we !== we) begin n_bad++; $display("FAIL %s port_we(mem) k=%0d: got %b want %b", tag, k, port_we, we); end
            n_cmp++; if (port_wdata !== wd) begin n_bad++; $display("FAIL %s port_wdata k=%0d: got %h want %h", tag, k, port_wdata, wd); end
         end
         if (busy_if) begin
            n_cmp++; if (port_addr !== ia) begin n_bad++; $display("FAIL %s port_addr(if) k=%0d: got %h want %h", tag, k, port_addr, ia); end
            n_cmp++; if (port_we !== 1'b0) begin n_bad++; $display("FAIL %s port_we(if) k=%0d: got %b want 0", tag, k, port_we); end
         end

         if (v_if) if_req = 1'b0;
         if (v_mem) mem_req = 1'b0;
         port_ready = 1'b0;
         port_rdata = $urandom;
         if (busy_mem && (lat_mem < TO) && (k == g_mem + lat_mem)) begin
            port_ready = 1'b1; port_rdata = rd_mem;
         end else if (busy_if && (lat_if < TO) && (k == g_if + lat_if)) begin
            port_ready = 1'b1; port_rdata = rd_if;
         end else if (stray && !exp_req && ($urandom_range(0, 3) == 0)) begin
            port_ready = 1'b1;
         end
         #1;
         exp_sm = mem_req && !v_mem;
         exp_si = (if_req && !v_if) || exp_sm;
         n_cmp++; if (stall_MEM !== exp_sm) begin n_bad++; $display("FAIL %s stall_MEM k=%0d: got %b want %b", tag, k, stall_MEM, exp_sm); end
         n_cmp++; if (stall_IF !== exp_si) begin n_bad++; $display("FAIL %s stall_IF k=%0d: got %b want %b", tag, k, stall_IF, exp_si); end
      end
      port_ready = 1'b0;
   endtask

   task automatic test_reset();
      if_req = 1'b1; mem_req = 1'b1; port_ready = 1'b1; port_rdata = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      apply_reset();
      n_cmp++; if ({port_req, port_we, if_valid, mem_valid, timeout_err} !== 5'b0) begin
         n_bad++; $display("FAIL reset_ctrl: got %b want 00000", {port_req, port_we, if_valid, mem_valid, timeout_err}); end
      n_cmp++; if (port_addr !== '0) begin n_bad++; $display("FAIL reset_port_addr: got %h want 0", port_addr); end
      n_cmp++; if (port_wdata !== '0) begin n_bad++; $display("FAIL reset_port_wdata: got %h want 0", port_wdata); end
      n_cmp++; if (if_rdata !== '0) begin n_bad++; $display("FAIL reset_if_rdata: got %h want 0", if_rdata); end
      n_cmp++; if (mem_rdata !== '0) begin n_bad++; $display("FAIL reset_mem_rdata: got %h want 0", mem_rdata); end
      n_cmp++; if ({stall_IF, stall_MEM} !== 2'b00) begin n_bad++; $display("FAIL reset_stalls: got %b want 00", {stall_IF, stall_MEM}); end
   endtask

   task automatic test_if_alone();
      apply_reset();
      run_arbitration("if_alone", 1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 32'h0, 3, 0, 32'h8C22_0004, 32'h0, 1'b0);
      n_cmp++; if (if_rdata !== 32'h8C22_0004) begin n_bad++; $display("FAIL if_alone_rdata: got %h want 8c220004", if_rdata); end
      n_cmp++; if (stall_IF !== 1'b0) begin n_bad++; $display("FAIL if_alone_stall_after: got %b want 0", stall_IF); end
   endtask

   task automatic test_priority();
      apply_reset();
      run_arbitration("priority", 1'b1, 1'b1, 1'b0, 32'h44, 32'h100, 32'h0, 2, 2, 32'h1111_2222, 32'hCAFE_F00D, 1'b0);
      n_cmp++; if (mem_rdata !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL priority_mem_rdata: got %h want cafef00d", mem_rdata); end
      n_cmp++; if (if_rdata !== 32'h1111_2222) begin n_bad++; $display("FAIL priority_if_rdata: got %h want 11112222", if_rdata); end
   endtask

   task automatic test_store();
      apply_reset();
      run_arbitration("load_before_store", 1'b0, 1'b1, 1'b0, 32'h0, 32'h180, 32'h0, 0, 1, 32'h0, 32'h0BAD_BEEF, 1'b0);
      run_arbitration("store", 1'b0, 1'b1, 1'b1, 32'h0, 32'h200, 32'h1234_5678, 0, 2, 32'h0, 32'hFFFF_0000, 1'b0);
      n_cmp++; if (mem_rdata !== 32'h0BAD_BEEF) begin n_bad++; $display("FAIL store_keeps_rdata: got %h want 0badbeef", mem_rdata); end
   endtask

   task automatic test_timeout();
      apply_reset();
      run_arbitration("ready_on_last", 1'b0, 1'b1, 1'b0, 32'h0, 32'h104, 32'h0, 0, TO - 1, 32'h0, 32'h5A5A_5A5A, 1'b0);
      n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL ready_on_last_err: got %b want 0", timeout_err); end
      run_arbitration("if_before_to", 1'b1, 1'b0, 1'b0, 32'h50, 32'h0, 32'h0, 2, 0, 32'h1357_2468, 32'h0, 1'b0);
      run_arbitration("if_timeout", 1'b1, 1'b0, 1'b0, 32'h54, 32'h0, 32'h0, TO, 0, 32'h9999_9999, 32'h0, 1'b0);
      n_cmp++; if (timeout_err !== 1'b1) begin n_bad++; $display("FAIL timeout_sets_err: got %b want 1", timeout_err); end
      n_cmp++; if (if_rdata !== 32'h0) begin n_bad++; $display("FAIL timeout_if_rdata: got %h want 0", if_rdata); end
      run_arbitration("after_timeout", 1'b1, 1'b0, 1'b0, 32'h58, 32'h0, 32'h0, 0, 0, 32'h2468_ACE0, 32'h0, 1'b0);
      n_cmp++; if (timeout_err !== 1'b1) begin n_bad++; $display("FAIL timeout_err_sticky: got %b want 1", timeout_err); end
      apply_reset();
      n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL timeout_err_reset: got %b want 0", timeout_err); end
   endtask

   task automatic test_back_to_back();
      apply_reset();
      if_req = 1'b1; if_addr = 32'h40; port_ready = 1'b0;
      step();
      port_ready = 1'b1; port_rdata = 32'hAAAA_0001;
      step();
      port_ready = 1'b0;
      n_cmp++; if (if_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_first_valid: got %b want 1", if_valid); end
      n_cmp++; if (if_rdata !== 32'hAAAA_0001) begin n_bad++; $display("FAIL b2b_first_rdata: got %h want aaaa0001", if_rdata); end
      if_addr = 32'h48;
      step();
      n_cmp++; if (port_req !== 1'b0) begin n_bad++; $display("FAIL b2b_no_regrant: got %b want 0", port_req); end
      n_cmp++; if (stall_IF !== 1'b1) begin n_bad++; $display("FAIL b2b_stall_represent: got %b want 1", stall_IF); end
      step();
      n_cmp++; if (port_req !== 1'b1) begin n_bad++; $display("FAIL b2b_second_grant: got %b want 1", port_req); end
      n_cmp++; if (port_addr !== 32'h48) begin n_bad++; $display("FAIL b2b_second_addr: got %h want 00000048", port_addr); end
      port_ready = 1'b1; port_rdata = 32'hAAAA_0002;
      step();
      port_ready = 1'b0;
      n_cmp++; if (if_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_second_valid: got %b want 1", if_valid); end
      n_cmp++; if (if_rdata !== 32'hAAAA_0002) begin n_bad++; $display("FAIL b2b_second_rdata: got %h want aaaa0002", if_rdata); end
      if_req = 1'b0;
      step();
      n_cmp++; if ({if_valid, port_req} !== 2'b00) begin n_bad++; $display("FAIL b2b_quiet: got %b want 00", {if_valid, port_req}); end
   endtask

   task automatic test_reset_mid();
      apply_reset();
      mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h300; mem_wdata = 32'h0;
      step();
      step();
      n_cmp++; if (port_req !== 1'b1) begin n_bad++; $display("FAIL midreset_busy: got %b want 1", port_req); end
      reset = 1'b1; mem_req = 1'b0;
      step();
      n_cmp++; if ({port_req, port_we, mem_valid, if_valid, timeout_err} !== 5'b0) begin
         n_bad++; $display("FAIL midreset_ctrl: got %b want 00000", {port_req, port_we, mem_valid, if_valid, timeout_err}); end
      n_cmp++; if (port_addr !== '0) begin n_bad++; $display("FAIL midreset_port_addr: got %h want 0", port_addr); end
      reset = 1'b0; port_ready = 1'b1; port_rdata = 32'hDEAD_BEEF;
      step();
      port_ready = 1'b0;
      n_cmp++; if ({mem_valid, port_req} !== 2'b00) begin n_bad++; $display("FAIL midreset_late_ready: got %b want 00", {mem_valid, port_req}); end
      n_cmp++; if (mem_rdata !== '0) begin n_bad++; $display("FAIL midreset_mem_rdata: got %h want 0", mem_rdata); end
      step();
      n_cmp++; if ({mem_valid, port_req, timeout_err} !== 3'b000) begin n_bad++; $display("FAIL midreset_settled: got %b want 000", {mem_valid, port_req, timeout_err}); end
      exp_err = 1'b0; exp_if_rd = '0; exp_mem_rd = '0;
   endtask

   task automatic test_random();
      bit [1:0]      sel;
      bit            we;
      int            li, lm;
      logic [AW-1:0] ia, ma;
      logic [DW-1:0] wd, ri, rm;
      apply_reset();
      for (int it = 0; it < 40; it++) begin
         sel = 2'($urandom_range(1, 3));
         we  = 1'($urandom_range(0, 1));
         li  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(TO - 2, TO + 2)) : int'($urandom_range(0, 4));
         lm  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(TO - 2, TO + 2)) : int'($urandom_range(0, 4));
         ia  = $urandom & 32'hFFFF_FFFC;
         ma  = $urandom & 32'hFFFF_FFFC;
         wd  = $urandom;
         ri  = $urandom;
         rm  = $urandom;
         run_arbitration("random", sel[0], sel[1], we, ia, ma, wd, li, lm, ri, rm, 1'b1);
         repeat ($urandom_range(0, 2)) step();
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached before summary");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_if_alone();
      test_priority();
      test_store();
      test_timeout();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
